// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the issue logic (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_div_core.sv
// One restoring-division step on unsigned magnitudes (built only with MDU_ITER_DIV_EN).
// Purely combinational, zero latency; the caller registers rem/quo each cycle.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/MTHI/MTLO with HI/LO; DIV/DIVU only when MDU_ITER_DIV_EN is defined.
// Iterative ops post results 34 cycles after accept; start is dropped (never queued) while busy.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);
  import mdu_pkg::*;

  mdu_state_e       state;
  mdu_op_e          op_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] mag_rs;
  logic [WIDTH-1:0] mag_rt;
  logic             sign_a;
  logic             sign_b;
  logic             op_signed;
  logic             is_div;
  logic [WIDTH:0]   mul_sum;

  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_rs    = (op_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign mag_rt    = (op_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef MDU_ITER_DIV_EN
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem     (acc_hi),
    .quo     (acc_lo),
    .divisor (opnd),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.div_by_zero <= (state == ST_IDLE) && bus.start && (bus.rt_val == '0) &&
                         ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
    end
  end
`else
  assign is_div          = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  // Remainder follows the dividend sign; quotient is negated when operand signs differ
  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (is_div) begin
      if (sign_a ^ sign_b) fix_lo = -acc_lo;
      if (sign_a)          fix_hi = -acc_hi;
    end else if ((op_q == OP_MULT) && (sign_a ^ sign_b)) begin
      {fix_hi, fix_lo} = -{acc_hi, acc_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt      <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: begin
                bus.hi   <= bus.rs_val;
                bus.done <= 1'b1;
              end
              OP_MTLO: begin
                bus.lo   <= bus.rs_val;
                bus.done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                op_q     <= mdu_op_e'(bus.op);
                sign_a   <= op_signed & bus.rs_val[WIDTH-1];
                sign_b   <= op_signed & bus.rt_val[WIDTH-1];
                opnd     <= mag_rs;
                acc_hi   <= '0;
                acc_lo   <= mag_rt;
                cnt      <= '0;
                bus.busy <= 1'b1;
                state    <= ST_MUL;
              end
`ifdef MDU_ITER_DIV_EN
              OP_DIV, OP_DIVU: begin
                if (bus.rt_val == '0) begin
                  bus.hi   <= bus.rs_val;
                  bus.lo   <= '1;
                  bus.done <= 1'b1;
                end else begin
                  op_q     <= mdu_op_e'(bus.op);
                  sign_a   <= op_signed & bus.rs_val[WIDTH-1];
                  sign_b   <= op_signed & bus.rt_val[WIDTH-1];
                  opnd     <= mag_rt;
                  acc_hi   <= '0;
                  acc_lo   <= mag_rs;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= ST_DIV;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
          if (cnt == 5'(ITER_COUNT - 1)) state <= ST_FIX;
        end
`ifdef MDU_ITER_DIV_EN
        ST_DIV: begin
          acc_hi <= rem_nxt;
          acc_lo <= quo_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == 5'(ITER_COUNT - 1)) state <= ST_FIX;
        end
`endif
        ST_FIX: begin
          bus.hi   <= fix_hi;
          bus.lo   <= fix_lo;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus random checks of mdu_iter against an arithmetic HI/LO model.
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_ITER_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then watch 40 cycles. inj_cyc: drive an MTLO while busy;
  // rst_cyc: pulse reset in that cycle; chain: issue MTLO of chain_val in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int rst_cyc, input bit chain,
                        input logic [31:0] chain_val, input string tag);
    logic [31:0] e_hi, e_lo, s_hi, s_lo;
    logic        s_dbz;
    bit          e_dbz, pending;
    int          e_done, e_busy, e_dcnt, done_cyc, done_cnt, busy_cnt;
    longint      ps, q, r;
    logic [63:0] pu;

    e_hi = m_hi; e_lo = m_lo; e_dbz = 1'b0; e_done = 0; e_busy = 0;
    case (op)
      OP_MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {e_hi, e_lo} = ps; e_done = 34; e_busy = 33;
      end
      OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {e_hi, e_lo} = pu; e_done = 34; e_busy = 33;
      end
      OP_DIV, OP_DIVU: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            e_hi = a; e_lo = 32'hFFFF_FFFF; e_dbz = 1'b1; e_done = 1;
          end else begin
            if (op == OP_DIV) begin
              q = longint'($signed(a)) / longint'($signed(b));
              r = longint'($signed(a)) % longint'($signed(b));
              e_lo = q[31:0]; e_hi = r[31:0];
            end else begin
              e_lo = a / b; e_hi = a % b;
            end
            e_done = 34; e_busy = 33;
          end
        end
      end
      OP_MTHI: begin e_hi = a; e_done = 1; end
      OP_MTLO: begin e_lo = a; e_done = 1; end
      default: ;
    endcase
    if (rst_cyc > 0) begin
      e_busy = (e_busy > 0) ? rst_cyc : 0;
      e_hi = '0; e_lo = '0; e_dbz = 1'b0; e_done = 0;
    end
    e_dcnt = (e_done != 0) ? (chain ? 2 : 1) : 0;

    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    pending = 1'b1;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    s_hi = '0; s_lo = '0; s_dbz = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (pending) begin bus.start = 1'b0; pending = 1'b0; end
      if (reset == 1'b0) reset = 1'b1;
      if (bus.done) done_cnt++;
      if (bus.done && done_cyc == 0) begin
        done_cyc = k; s_hi = bus.hi; s_lo = bus.lo; s_dbz = bus.div_by_zero;
        if (chain) begin
          bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_val = chain_val; pending = 1'b1;
        end
      end
      if (bus.busy) busy_cnt++;
      if (k == inj_cyc) begin
        bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_val = 32'hDEAD_BEEF; pending = 1'b1;
      end
      if (k == rst_cyc) reset = 1'b0;
    end

    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(e_done));
    chk({tag, ".done_count"}, 64'(done_cnt), 64'(e_dcnt));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(e_busy));
    chk({tag, ".dbz"}, 64'(s_dbz), 64'(e_dbz));
    if (e_done != 0) begin
      chk({tag, ".hi_at_done"}, 64'(s_hi), 64'(e_hi));
      chk({tag, ".lo_at_done"}, 64'(s_lo), 64'(e_lo));
    end
    if (chain && e_done != 0) e_lo = chain_val;
    m_hi = e_hi; m_lo = e_lo;
    chk({tag, ".hi_hold"}, 64'(bus.hi), 64'(m_hi));
    chk({tag, ".lo_hold"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0; bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.hi", 64'(bus.hi), 64'd0);
    chk("reset.lo", 64'(bus.lo), 64'd0);
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         5, 0, 1'b0, '0, "mult_neg_inj");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, '0, "multu_max");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 1'b0, '0, "div_neg7_2");
    run_op(OP_DIVU,  32'd7,         32'd0,         0, 0, 1'b0, '0, "divu_by0");
    run_op(OP_MTHI,  32'h0000_1234, 32'd0,         0, 0, 1'b1, 32'h55AA_00FF, "mthi_chain");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, '0, "div_ovf");
    run_op(OP_DIV,   32'd100,       32'hFFFF_FFFD, 0, 0, 1'b1, 32'h0BAD_F00D, "div_chain");
    run_op(3'd6,     32'h1111_1111, 32'd5,         0, 0, 1'b0, '0, "undef6");
    run_op(OP_MTLO,  32'hCAFE_0001, 32'd0,         0, 0, 1'b0, '0, "mtlo");
    run_op(OP_DIV,   32'd1000,      32'd7,         0, 10, 1'b0, '0, "div_reset");
    run_op(OP_MULTU, 32'd6,         32'd7,         0, 0, 1'b0, '0, "multu_6x7");
    run_op(3'd7,     32'h2222_2222, 32'd1,         0, 0, 1'b0, '0, "undef7");

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0, 0, 1'b0, '0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
